// File: rtl/sclk_gen_pkg.sv
// sclk_gen_pkg: shared types and default widths for the SPI serial-clock
// burst generator (FSM state encoding, default parameter values).
package sclk_gen_pkg;

  localparam int DIV_WIDTH_DEF = 16;
  localparam int CNT_WIDTH_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_RUN   = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/half_period_timer.sv
// half_period_timer: counts 0..limit_i while enabled and wraps to 0.
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : synchronous clear to 0 (wins over enable)
//   en_i          : count enable
//   limit_i       : terminal count (half-period minus one)
//   tick_o        : high in the cycle the counter sits at limit_i while enabled
module half_period_timer #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         tick_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == limit_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (tick_o) cnt_d = '0;
    else if (en_i)   cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sclk_burst_generator.sv
// sclk_burst_generator: runtime-programmable SPI SCLK burst generator.
// Divides input_clock by (div+1) per half-period, emits nbits SCLK cycles in
// any CPOL/CPHA mode and flags each edge with a registered sample/shift strobe.
//   input_clock, reset_n : clock, async active-low reset
//   start                : burst request, taken only when idle and not busy/done
//   div, nbits, cpol, cpha : burst configuration, latched on accepted start
//   free_run             : (SCLK_GEN_FREERUN_EN only) run until deasserted
//   sclk                 : registered serial clock
//   sample_stb/shift_stb : 1-cycle strobes in the cycle sclk shows its new edge
//   busy, done           : burst in progress / 1-cycle completion pulse
// Optional feature macro: SCLK_GEN_FREERUN_EN.
module sclk_burst_generator
  import sclk_gen_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 input_clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [CNT_WIDTH-1:0] nbits,
  input  logic                 cpol,
  input  logic                 cpha,
`ifdef SCLK_GEN_FREERUN_EN
  input  logic                 free_run,
`endif
  output logic                 sclk,
  output logic                 sample_stb,
  output logic                 shift_stb,
  output logic                 busy,
  output logic                 done
);

  localparam int EW = CNT_WIDTH + 1;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [CNT_WIDTH-1:0] nbits_q, nbits_d;
  logic [EW-1:0]        edge_q, edge_d, edge_inc;
  logic                 cpol_q, cpol_d, cpha_q, cpha_d;
  logic                 sclk_q, sclk_d, samp_q, samp_d, shft_q, shft_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 tick, tmr_clr, lead, fin;

`ifdef SCLK_GEN_FREERUN_EN
  logic free_q, free_d, stop_q, stop_d;
`endif

  half_period_timer #(.W(DIV_WIDTH)) u_timer (
    .clk_i  (input_clock),
    .rst_ni (reset_n),
    .clr_i  (tmr_clr),
    .en_i   (state_q != ST_IDLE),
    .limit_i(div_q),
    .tick_o (tick)
  );

  // sclk at its idle level means the next edge is the leading one
  assign lead     = (sclk_q == cpol_q);
  assign edge_inc = (edge_q == '1) ? edge_q : edge_q + EW'(1);

`ifdef SCLK_GEN_FREERUN_EN
  // once free_run has dropped, finish on the next trailing edge
  assign fin = free_q ? ((stop_q || !free_run) && !lead)
                      : (edge_inc == {nbits_q, 1'b0});
`else
  assign fin = (edge_inc == {nbits_q, 1'b0});
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    nbits_d = nbits_q;
    edge_d  = edge_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    sclk_d  = sclk_q;
    busy_d  = busy_q;
    samp_d  = 1'b0;
    shft_d  = 1'b0;
    done_d  = 1'b0;
    tmr_clr = 1'b0;
`ifdef SCLK_GEN_FREERUN_EN
    free_d  = free_q;
    stop_d  = stop_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cpol_d = cpol;
        sclk_d = cpol;
        busy_d = 1'b0;
        // done_q blocks a start presented in the completion cycle
        if (start && !busy_q && !done_q) begin
          div_d   = div;
          nbits_d = nbits;
          cpha_d  = cpha;
          edge_d  = '0;
          tmr_clr = 1'b1;
          busy_d  = 1'b1;
`ifdef SCLK_GEN_FREERUN_EN
          free_d  = free_run;
          stop_d  = 1'b0;
          if (nbits == '0 && !free_run) done_d = 1'b1;
          else                          state_d = ST_SETUP;
`else
          if (nbits == '0) done_d = 1'b1;
          else             state_d = ST_SETUP;
`endif
        end
      end
      ST_SETUP, ST_RUN: begin
`ifdef SCLK_GEN_FREERUN_EN
        if (!free_run) stop_d = 1'b1;
`endif
        if (tick) begin
          sclk_d  = ~sclk_q;
          edge_d  = edge_inc;
          samp_d  = lead ^ cpha_q;
          shft_d  = ~(lead ^ cpha_q);
          state_d = fin ? ST_HOLD : ST_RUN;
        end
      end
      ST_HOLD: begin
        if (tick) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge input_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      nbits_q <= '0;
      edge_q  <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      sclk_q  <= 1'b0;
      samp_q  <= 1'b0;
      shft_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SCLK_GEN_FREERUN_EN
      free_q  <= 1'b0;
      stop_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      nbits_q <= nbits_d;
      edge_q  <= edge_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      sclk_q  <= sclk_d;
      samp_q  <= samp_d;
      shft_q  <= shft_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SCLK_GEN_FREERUN_EN
      free_q  <= free_d;
      stop_q  <= stop_d;
`endif
    end
  end

  assign sclk       = sclk_q;
  assign sample_stb = samp_q;
  assign shift_stb  = shft_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
